// File: rtl/rf_wr_arbiter_if.sv
// Register-file write-port bus: write-back request, side-unit request,
// and the arbitrated register-file write port.
interface rf_wr_arbiter_if;
  // write-back stage request
  logic       P_RW;
  logic [2:0] P_DA;
  logic [7:0] P_D;
  // side unit request
  logic       S_VALID;
  logic [2:0] S_DA;
  logic [7:0] S_D;
  logic       S_READY;
  // pipeline hold
  logic       STALL;
  // register-file write port
  logic       RWO;
  logic [2:0] DAO;
  logic [7:0] BuD;

  // requester side (write-back stage, side unit, register file)
  modport master (
    output P_RW, P_DA, P_D, S_VALID, S_DA, S_D,
    input  S_READY, STALL, RWO, DAO, BuD
  );

  // arbiter side
  modport slave (
    input  P_RW, P_DA, P_D, S_VALID, S_DA, S_D,
    output S_READY, STALL, RWO, DAO, BuD
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the single register-file write port between the
// write-back stage (priority) and a side unit buffered in a small FIFO.
// A starvation guard raises STALL so a live side entry is eventually written.
// Optional macro RF_WR_STATS_EN adds saturating STALL_CNT / KILL_CNT outputs.
module rf_wr_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  rf_wr_arbiter_if.slave  bus
`ifdef RF_WR_STATS_EN
  ,
  output logic [15:0]     STALL_CNT,
  output logic [15:0]     KILL_CNT
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // FIFO storage and bookkeeping
  logic [2:0]    da_q   [DEPTH];
  logic [7:0]    d_q    [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    starve_q, starve_d;

  // registered write port
  logic          rwo_q, rwo_d;
  logic [2:0]    dao_q, dao_d;
  logic [7:0]    bud_q, bud_d;

  logic          full, empty, push, pop;
  logic          head_live, dead_head, stall;
  logic          grant_side, grant_pipe;
  logic [DEPTH-1:0] valid_v, kill_v;
  logic          any_kill;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign push       = bus.S_VALID && !full;
  assign head_live  = !empty && live_q[rd_ptr_q];
  assign dead_head  = !empty && !live_q[rd_ptr_q];
  assign stall      = head_live && (starve_q >= 4'(STARVE_MAX));
  assign grant_side = stall || (!bus.P_RW && head_live);
  assign grant_pipe = !stall && bus.P_RW;
  // a dead head is only ever popped when the side is not granted
  assign pop        = grant_side || dead_head;
  assign any_kill   = |kill_v;

  assign bus.S_READY = !full;
  assign bus.STALL   = stall;
  assign bus.RWO     = rwo_q;
  assign bus.DAO     = dao_q;
  assign bus.BuD     = bud_q;

  // Occupied slots, and which live entries a pipeline write supersedes
  always_comb begin
    valid_v = '0;
    kill_v  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off        = PW'(i) - rd_ptr_q;
      valid_v[i] = ({1'b0, off} < count_q);
      kill_v[i]  = grant_pipe && valid_v[i] && live_q[i] && (da_q[i] == bus.P_DA);
    end
  end

  // Next write-port value, occupancy and starvation count
  always_comb begin
    rwo_d    = 1'b0;
    dao_d    = dao_q;
    bud_d    = bud_q;
    if (grant_side) begin
      rwo_d = 1'b1;
      dao_d = da_q[rd_ptr_q];
      bud_d = d_q[rd_ptr_q];
    end else if (grant_pipe) begin
      rwo_d = 1'b1;
      dao_d = bus.P_DA;
      bud_d = bus.P_D;
    end

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    starve_d = starve_q;
    if (pop || !head_live)                   starve_d = '0;
    else if (grant_pipe && starve_q != 4'hF) starve_d = starve_q + 1'b1;
  end

  // FIFO state; kills apply to existing entries, the same-cycle push lands live
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        da_q[i] <= '0;
        d_q[i]  <= '0;
      end
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill_v[i]) live_q[i] <= 1'b0;
      end
      if (push) begin
        da_q[wr_ptr_q]   <= bus.S_DA;
        d_q[wr_ptr_q]    <= bus.S_D;
        live_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Registered register-file write port
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rwo_q <= 1'b0;
      dao_q <= '0;
      bud_q <= '0;
    end else begin
      rwo_q <= rwo_d;
      dao_q <= dao_d;
      bud_q <= bud_d;
    end
  end

`ifdef RF_WR_STATS_EN
  logic [15:0] stall_cnt_q, kill_cnt_q;

  assign STALL_CNT = stall_cnt_q;
  assign KILL_CNT  = kill_cnt_q;

  // Saturating event counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      if (stall && stall_cnt_q != '1)   stall_cnt_q <= stall_cnt_q + 1'b1;
      if (any_kill && kill_cnt_q != '1) kill_cnt_q  <= kill_cnt_q + 1'b1;
    end
  end
`endif

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the single 8-bit register-file write port between two requesters: the pipeline write-back stage (priority) and a multi-cycle side unit (e.g. multiplier/load return).
- Side requests are buffered in a small FIFO and drained in cycles where write-back is idle.
- A starvation guard stalls the pipeline for one cycle so the side unit always makes progress.
- Sits between the write-back stage outputs and the register-file write port (RW/DA/data).

Parameters:
DEPTH, 2, side FIFO entries; power of 2, range 2..8
STARVE_MAX, 4, consecutive cycles a live FIFO head may be bypassed before STALL is forced; range 1..15

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
P_RW  in  1  write-back stage write request
P_DA  in  3  write-back destination register
P_D  in  8  write-back data
S_VALID  in  1  side unit request valid
S_DA  in  3  side destination register
S_D  in  8  side data
S_READY  out  1  FIFO can accept; equals !full
STALL  out  1  pipeline must hold write-back contents this cycle
RWO  out  1  register-file write enable (registered)
DAO  out  3  register-file write address (registered)
BuD  out  8  register-file write data (registered)

Behaviour:
- Reset (async, RST_N=0): FIFO flushed (pointers, count, live bits = 0), starve_cnt=0, RWO=0, DAO=0, BuD=0. STALL=0 and S_READY=1 while in reset. Reset mid-operation discards all buffered requests; no write is emitted.
- FIFO:
  - Push on S_VALID && S_READY; each entry holds {DA, D, live=1}.
  - Pointers wrap modulo DEPTH.
  - No pop-through: when full, S_READY=0 even if a pop occurs in the same cycle.
- Head "live" = FIFO non-empty and the head entry's live bit is set.
- Dead head: if the FIFO is non-empty and the head is not live, it is popped at the next edge with no write and no grant consumed. Only one pop per cycle.
- STALL (combinational) = live head && starve_cnt >= STARVE_MAX.
- Grant priority, evaluated each cycle:
  1. STALL=1: grant side. Pop head; write {head.DA, head.D} next edge. P_RW is ignored (pipeline holds it); no kill.
  2. P_RW=1: grant pipeline. Write {P_DA, P_D} next edge. Every buffered entry with DA==P_DA has its live bit cleared (newer value wins). An entry pushed in this same cycle is treated as newer and is not killed.
  3. Live head: grant side. Pop and write the head.
  4. Otherwise RWO=0 next edge; DAO and BuD hold their previous values.
- Latency: 1 cycle from grant to RWO/DAO/BuD. Side path minimum 2 cycles (push edge, then grant).
- starve_cnt (4-bit):
  - Cleared on any pop or when no live head.
  - Increments, saturating at 15, when a live head exists and the pipeline is granted.
- Simultaneous push into an empty FIFO with P_RW=0: the entry is not granted in the same cycle (head visible next cycle).
- Writes to register 0 are passed through unchanged; the arbiter applies no special handling.

Optional Feature:
- Macro: RF_WR_STATS_EN.
- Defined: adds ports STALL_CNT out 16 and KILL_CNT out 16.
  - STALL_CNT increments each cycle STALL=1.
  - KILL_CNT increments once per cycle in which at least one entry is killed.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, P_RW=0, S_VALID=0 -> RWO=0, DAO=0, BuD=0, S_READY=1, STALL=0.
- P_RW=1, P_DA=3, P_D=8'h5A for one cycle -> next edge RWO=1, DAO=3, BuD=8'h5A; following cycle RWO=0.
- FIFO empty, push S_DA=2, S_D=8'h11 with P_RW held 0 -> RWO=1, DAO=2, BuD=8'h11 two edges after the push. With DEPTH=2, two pushes while P_RW=1 leave S_READY=0.
- Push S_DA=4, S_D=8'hAA, then hold P_RW=1 continuously (STARVE_MAX=4) -> STALL=1 on the 5th pipeline-busy cycle; the next edge writes DAO=4, BuD=8'hAA; STALL=0 afterwards.
- Push S_DA=6, S_D=8'h01; next cycle P_RW=1, P_DA=6, P_D=8'h02 -> write 6<-8'h02 only; the dead entry is dropped and no write of 8'h01 ever occurs. With RF_WR_STATS_EN defined, KILL_CNT=1.
- Assert RST_N=0 mid-stream with 2 entries buffered -> outputs 0 immediately; after release no stale writes are emitted.
